cnn_layer_sequencer: RTL
========================

# cnn_layer_sequencer

Top-level layer scheduler for the CNN inference pipeline. It accepts one start pulse per image and launches each layer engine (conv, relu, maxpool, dense, ...) in fixed order, one at a time, over a per-stage start/done pulse handshake. It adds a per-stage watchdog with a latched fault, an abort path and a whole-inference cycle counter for performance measurement.

## Interface
- NUM_STAGES, 4, number of sequenced layer engines; stage 0 runs first (≥2)
- TIMEOUT_CYCLES, 65536, WAIT cycles allowed per stage before fault; 0 disables the watchdog
- CNT_WIDTH, 24, width of total_cycles
- Derived localparam: STAGE_W = max(1, $clog2(NUM_STAGES))

Ports:
- clk  in  1  system clock, all logic on posedge
- reset  in  1  asynchronous, active-high; all state and outputs cleared
- start  in  1  single-cycle request to run one inference
- abort  in  1  cancel in-progress inference
- clear  in  1  clears a latched fault
- stage_done  in  NUM_STAGES  per-stage completion pulse
- stage_start  out  NUM_STAGES  one-hot, single-cycle launch pulse
- busy  out  1  high in LAUNCH/WAIT
- done  out  1  single-cycle pulse on successful completion
- error  out  1  high while in FAULT
- cur_stage  out  STAGE_W  index of the stage being launched or awaited
- err_stage  out  STAGE_W  stage that timed out, latched
- total_cycles  out  CNT_WIDTH  LAUNCH+WAIT cycles of last/current run

## Operation
- States: IDLE, LAUNCH, WAIT, FINISH, FAULT. Reset → IDLE.
- Reset values: stage_start=0, busy=0, done=0, error=0, cur_stage=0, err_stage=0, total_cycles=0, watchdog=0.
- IDLE: start=1 and abort=0 → LAUNCH, cur_stage←0, total_cycles←0. start with abort=1 is ignored.
- LAUNCH (exactly 1 cycle): stage_start[cur_stage]=1, all other bits 0; watchdog←0; → WAIT. stage_done is ignored in this cycle.
- WAIT, checked in priority order:
  - abort → IDLE.
  - stage_done[cur_stage]=1 → if cur_stage==NUM_STAGES-1 go to FINISH, else cur_stage+1 and LAUNCH.
  - TIMEOUT_CYCLES≠0 and watchdog==TIMEOUT_CYCLES-1 → FAULT, err_stage←cur_stage.
  - Otherwise watchdog+1.
- Done beats timeout in the same cycle. stage_done bits for stages other than cur_stage are ignored everywhere.
- FINISH (1 cycle): done=1; → IDLE, cur_stage←0.
- FAULT: error=1, busy=0. start and abort are ignored. clear=1 → IDLE next cycle, cur_stage←0. err_stage holds until the next fault or reset.
- abort in LAUNCH also → IDLE; that cycle's stage_start pulse is still emitted. An aborted run never pulses done. total_cycles holds its partial value after abort.
- total_cycles increments every cycle in LAUNCH or WAIT and saturates at all-ones. It holds in IDLE/FINISH/FAULT until the next accepted start.
- start seen outside IDLE is dropped, with no queueing.
- Asynchronous reset mid-run: state returns to IDLE immediately. Outputs take their reset values without waiting for a clock edge.

## Timing
- All outputs are registered or decoded solely from registered state, so they are glitch-free.
- Start accepted at edge N: stage_start[0] high in cycle N+1.
- stage_done[k] sampled high in WAIT at cycle M: stage_start[k+1] high in cycle M+1.
- stage_done of the last stage at cycle M: done high in cycle M+1; busy low from cycle M+1.
- Minimum per-stage cost is 2 cycles (LAUNCH + 1 WAIT). Minimum start-to-done latency is 2·NUM_STAGES+1 cycles.
- Watchdog: FAULT is entered after TIMEOUT_CYCLES consecutive WAIT cycles without done; error rises the following cycle.
- Back-to-back runs: a new start is accepted in the cycle after FINISH, i.e. while done is high the block is already leaving FINISH. start during FINISH is dropped.

## Test plan
- Nominal run, NUM_STAGES=4, each engine pulses done 1 cycle after its start:
  - start at cycle 0 → stage_start one-hot pulses at cycles 1, 3, 5, 7.
  - done=1 at cycle 9; total_cycles=8; busy high cycles 1–8.
- Variable latency, engine delays 3/0/700/5 WAIT cycles past the first WAIT:
  - Strict ordering holds and each next launch occurs exactly 1 cycle after the corresponding done.
  - total_cycles = 8 + 708 = 716.
- Watchdog, TIMEOUT_CYCLES=16, stage 2 never responds:
  - error rises after 16 WAIT cycles in stage 2; err_stage=2; done never asserts; start is ignored.
  - clear → IDLE; the next start runs normally with err_stage still 2.
- Edge priorities:
  - done and timeout in the same cycle (done on the 16th WAIT cycle) → no fault, sequence advances.
  - Spurious stage_done[3] during stage 1 → ignored.
  - start during WAIT → ignored, no second run.
- Abort:
  - abort in WAIT of stage 1 → IDLE next cycle, no done, total_cycles frozen.
  - abort together with start in IDLE → stays IDLE.
- Reset mid-run: assert reset asynchronously (between edges) during stage 2 WAIT → all outputs 0 immediately, before the next edge. After deassertion, start produces a clean run from stage 0.

Source files
------------

// File: rtl/cnn_layer_sequencer.sv
// cnn_layer_sequencer: launches the layer engines one at a time in fixed order
// over a start/done pulse handshake. A watchdog bounds every wait, an abort
// cancels a run, and total_cycles measures the busy time of the last run.
//
// state  | meaning
// -------+---------------------------------------------------------------
// IDLE   | waiting for an accepted start
// LAUNCH | one-cycle stage_start pulse for cur_stage
// WAIT   | waiting for stage_done[cur_stage]; watchdog counting down
// FINISH | one-cycle done pulse, run completed
// FAULT  | watchdog expired; error held until clear
module cnn_layer_sequencer #(
    parameter int NUM_STAGES     = 4,
    parameter int TIMEOUT_CYCLES = 65536,
    parameter int CNT_WIDTH      = 24,
    localparam int STAGE_W       = (NUM_STAGES > 2) ? $clog2(NUM_STAGES) : 1
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  start,
    input  logic                  abort,
    input  logic                  clear,
    input  logic [NUM_STAGES-1:0] stage_done,
    output logic [NUM_STAGES-1:0] stage_start,
    output logic                  busy,
    output logic                  done,
    output logic                  error,
    output logic [STAGE_W-1:0]    cur_stage,
    output logic [STAGE_W-1:0]    err_stage,
    output logic [CNT_WIDTH-1:0]  total_cycles
);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_LAUNCH = 3'd1,
        S_WAIT   = 3'd2,
        S_FINISH = 3'd3,
        S_FAULT  = 3'd4
    } state_t;

    // The watchdog is a down-counter loaded in LAUNCH; a zero in WAIT means
    // TIMEOUT_CYCLES wait cycles have elapsed without a done.
    localparam logic [31:0] WD_LOAD = (TIMEOUT_CYCLES == 0) ? 32'd0 : 32'(TIMEOUT_CYCLES - 1);
    localparam bit          WD_EN   = (TIMEOUT_CYCLES != 0);
    localparam logic [STAGE_W-1:0] LAST_STAGE = STAGE_W'(NUM_STAGES - 1);

    state_t               state, state_nx;
    logic [STAGE_W-1:0]   cur_nx, err_nx;
    logic [CNT_WIDTH-1:0] total_nx;
    logic [31:0]          wd_cnt, wd_nx;

    // State and datapath registers; async reset returns everything to IDLE.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state        <= S_IDLE;
            cur_stage    <= '0;
            err_stage    <= '0;
            total_cycles <= '0;
            wd_cnt       <= '0;
        end else begin
            state        <= state_nx;
            cur_stage    <= cur_nx;
            err_stage    <= err_nx;
            total_cycles <= total_nx;
            wd_cnt       <= wd_nx;
        end
    end

    // Next-state, stage index, watchdog and cycle-counter updates.
    always_comb begin
        state_nx = state;
        cur_nx   = cur_stage;
        err_nx   = err_stage;
        total_nx = total_cycles;
        wd_nx    = wd_cnt;

        if ((state == S_LAUNCH || state == S_WAIT) && total_cycles != '1)
            total_nx = total_cycles + CNT_WIDTH'(1);

        case (state)
            S_IDLE: begin
                if (start && !abort) begin
                    state_nx = S_LAUNCH;
                    cur_nx   = '0;
                    total_nx = '0;
                end
            end
            S_LAUNCH: begin
                wd_nx    = WD_LOAD;
                state_nx = abort ? S_IDLE : S_WAIT;
                if (abort)
                    cur_nx = '0;
            end
            S_WAIT: begin
                if (abort) begin
                    state_nx = S_IDLE;
                    cur_nx   = '0;
                end else if (stage_done[cur_stage]) begin
                    if (cur_stage == LAST_STAGE) begin
                        state_nx = S_FINISH;
                    end else begin
                        state_nx = S_LAUNCH;
                        cur_nx   = cur_stage + STAGE_W'(1);
                    end
                end else if (WD_EN && wd_cnt == 32'd0) begin
                    state_nx = S_FAULT;
                    err_nx   = cur_stage;
                end else if (wd_cnt != 32'd0) begin
                    wd_nx = wd_cnt - 32'd1;
                end
            end
            S_FINISH: begin
                state_nx = S_IDLE;
                cur_nx   = '0;
            end
            S_FAULT: begin
                if (clear) begin
                    state_nx = S_IDLE;
                    cur_nx   = '0;
                end
            end
            default: begin
                state_nx = S_IDLE;
                cur_nx   = '0;
            end
        endcase
    end

    // Outputs decoded only from registered state, so they cannot glitch.
    always_comb begin
        stage_start = '0;
        if (state == S_LAUNCH)
            stage_start[cur_stage] = 1'b1;
        busy  = (state == S_LAUNCH) || (state == S_WAIT);
        done  = (state == S_FINISH);
        error = (state == S_FAULT);
    end

endmodule
